ppm16_frame_ctrl: RTL and testbench
===================================

PPM16_FRAME_CTRL -- requirements
Module: ppm16_frame_ctrl

Interface
REQ-001 Parameter CHIP_BITS, default 1, sets the width of one chip sample; all chip, peak and threshold ports SHALL use this width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 en  input  1  run enable; low forces IDLE.
REQ-005 frame_sync  input  1  one-cycle pulse marking slot 0 of a new frame.
REQ-006 chip_in  input  CHIP_BITS  chip sample, qualified by chip_valid.
REQ-007 chip_valid  input  1  chip_in valid this cycle.
REQ-008 cfg_threshold  input  CHIP_BITS  correlation threshold request.
REQ-009 cnt_clr  input  1  synchronous clear of both counters.
REQ-010 corr_chips  output  16*CHIP_BITS  frame handed to the correlator; slot k occupies bits [k*CHIP_BITS +: CHIP_BITS].
REQ-011 corr_valid  output  1  correlator input_valid.
REQ-012 corr_threshold  output  CHIP_BITS  threshold driven to the correlator.
REQ-013 corr_symbol  input  4  correlator winning index (combinational).
REQ-014 corr_peak  input  CHIP_BITS  correlator peak value.
REQ-015 corr_unmet  input  1  correlator threshold_unmet.
REQ-016 sym_out  output  4  decoded symbol.
REQ-017 sym_peak  output  CHIP_BITS  peak belonging to sym_out.
REQ-018 sym_erased  output  1  symbol failed threshold.
REQ-019 sym_valid  output  1  output holds an unaccepted symbol.
REQ-020 sym_ready  input  1  consumer accepts the symbol when it is high together with sym_valid.
REQ-021 overflow  output  1  sticky flag: a symbol was dropped.
REQ-022 sym_count  output  16  symbols delivered to the output register.
REQ-023 erase_count  output  16  erased symbols delivered.

Function
REQ-024 The FSM SHALL have three states: IDLE, COLLECT and EVAL.
- IDLE->COLLECT: en=1.
- COLLECT->EVAL: the cycle slot 15 is written.
- EVAL->COLLECT: unconditionally after 1 cycle.
- Any state->IDLE: en=0, except that EVAL SHALL first complete its capture.
REQ-025 In COLLECT and EVAL, each chip_valid SHALL write chip_in into buffer slot slot_idx, and slot_idx (4 bits) SHALL then increment, wrapping 15->0.
REQ-026 frame_sync SHALL set slot_idx to 0 and discard the partial frame; if chip_valid is high in the same cycle, the chip SHALL go to slot 0 and slot_idx SHALL become 1.
REQ-027 On the edge that writes slot 15, all 16 slots SHALL be copied to corr_chips and cfg_threshold SHALL be latched into corr_threshold; corr_valid SHALL be 1 for exactly the following cycle (EVAL).
- Outside EVAL, corr_valid SHALL be 0 and corr_chips SHALL hold its value.
REQ-028 Collection SHALL continue during EVAL; a chip arriving in EVAL SHALL go to slot 0 of the next frame.
REQ-029 At the end of EVAL, corr_symbol, corr_peak and corr_unmet SHALL be captured into sym_out, sym_peak and sym_erased, and sym_valid SHALL be set, if the output register is free.
- Free means sym_valid=0, or sym_valid=1 with sym_ready=1 in that cycle.
REQ-030 If the output register is not free at the end of EVAL, the new symbol SHALL be dropped, the old symbol SHALL be retained, overflow SHALL be set, and neither counter SHALL change.
REQ-031 sym_valid SHALL clear on acceptance unless a capture occurs on the same edge; sym_out, sym_peak and sym_erased SHALL be stable while sym_valid=1.
REQ-032 Latency: slot-15 write at edge E0; corr_valid high in cycle E0..E1; sym_valid high after E1 (2 clocks).
REQ-033 On each capture, sym_count SHALL increment, and erase_count SHALL also increment if corr_unmet=1; both SHALL saturate at 16'hFFFF.
REQ-034 cnt_clr SHALL zero both counters and SHALL take priority over a same-cycle increment.
REQ-035 Leaving COLLECT/EVAL to IDLE SHALL zero slot_idx and discard the partial frame; a pending output symbol SHALL remain until accepted.
REQ-036 overflow SHALL clear only on reset or on an en 0->1 transition.

Reset
REQ-037 While rst=1, the block SHALL be in IDLE with slot_idx=0, all buffer slots=0, corr_chips=0, corr_valid=0, corr_threshold=0, sym_out=0, sym_peak=0, sym_erased=0, sym_valid=0, overflow=0, sym_count=0 and erase_count=0.
REQ-038 Reset asserted mid-frame or during EVAL SHALL abort immediately with no symbol capture.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- CHIP_BITS=1, cfg_threshold=1, sync, then 16 chips with slot 5 only =1, sym_ready=1 -> corr_valid one cycle after the 16th chip; sym_out=5, sym_erased=0, sym_valid 2 clocks after the last chip; sym_count=1.
- All-zero frame, threshold=1 -> sym_erased=1 and erase_count=1.
- sym_ready=0 held across two frames -> the first symbol is retained, overflow=1 and sym_count=1; after sym_ready=1 the second frame's symbol is absent.
- frame_sync after 7 chips, then 16 chips with slot 2 high -> sym_out=2; the partial frame never produces corr_valid.
- Continuous chip_valid for 32 cycles -> two corr_valid pulses 16 cycles apart and no lost chip in EVAL.
- rst asserted at chip 10 -> all outputs at reset values immediately; after release and en=1, the next full frame decodes correctly.

Source files
------------

// File: rtl/ppm16_frame_ctrl_if.sv
// Chip-stream, correlator and symbol-output signals of the 16-slot PPM frame controller.
// slave is the controller side, master is the environment (chip source, correlator, consumer).
interface ppm16_frame_ctrl_if #(parameter int CHIP_BITS = 1);
    logic                     en;
    logic                     frame_sync;
    logic [CHIP_BITS-1:0]     chip_in;
    logic                     chip_valid;
    logic [CHIP_BITS-1:0]     cfg_threshold;
    logic                     cnt_clr;
    logic [16*CHIP_BITS-1:0]  corr_chips;
    logic                     corr_valid;
    logic [CHIP_BITS-1:0]     corr_threshold;
    logic [3:0]               corr_symbol;
    logic [CHIP_BITS-1:0]     corr_peak;
    logic                     corr_unmet;
    logic [3:0]               sym_out;
    logic [CHIP_BITS-1:0]     sym_peak;
    logic                     sym_erased;
    logic                     sym_valid;
    logic                     sym_ready;
    logic                     overflow;
    logic [15:0]              sym_count;
    logic [15:0]              erase_count;

    modport slave (
        input  en, frame_sync, chip_in, chip_valid, cfg_threshold, cnt_clr,
               corr_symbol, corr_peak, corr_unmet, sym_ready,
        output corr_chips, corr_valid, corr_threshold, sym_out, sym_peak,
               sym_erased, sym_valid, overflow, sym_count, erase_count
    );

    modport master (
        output en, frame_sync, chip_in, chip_valid, cfg_threshold, cnt_clr,
               corr_symbol, corr_peak, corr_unmet, sym_ready,
        input  corr_chips, corr_valid, corr_threshold, sym_out, sym_peak,
               sym_erased, sym_valid, overflow, sym_count, erase_count
    );
endinterface

// File: rtl/ppm16_frame_ctrl.sv
// Collects 16 PPM chips into a frame, hands it to an external correlator for one cycle,
// and registers the decoded symbol behind a valid/ready output with drop/overflow and counters.
module ppm16_frame_ctrl #(
    parameter int CHIP_BITS = 1
) (
    input  logic               clk,
    input  logic               rst,
    ppm16_frame_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, COLLECT, EVAL} state_t;

    state_t                          state_q, state_d;
    logic [3:0]                      slot_idx, wr_idx;
    logic [15:0][CHIP_BITS-1:0]      buf_q, buf_nxt, chips_q;
    logic [CHIP_BITS-1:0]            thr_q;
    logic [3:0]                      sym_q;
    logic [CHIP_BITS-1:0]            peak_q;
    logic                            erased_q, sym_vld_q, ovf_q, en_q;
    logic [15:0]                     sym_cnt_q, era_cnt_q;
    logic                            active, wr_en, last_wr, go_idle, out_free, capture, drop;

    assign active   = (state_q != IDLE);
    assign wr_idx   = bus.frame_sync ? 4'd0 : slot_idx;
    assign wr_en    = active && bus.chip_valid;
    assign last_wr  = (state_q == COLLECT) && bus.en && wr_en && (wr_idx == 4'd15);
    assign go_idle  = active && !bus.en;
    assign out_free = !sym_vld_q || bus.sym_ready;
    // EVAL always finishes its capture decision, even when en has dropped.
    assign capture  = (state_q == EVAL) && out_free;
    assign drop     = (state_q == EVAL) && !out_free;

    always_comb begin
        buf_nxt = buf_q;
        if (wr_en) buf_nxt[wr_idx] = bus.chip_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.en) state_d = COLLECT;
            COLLECT: if (!bus.en) state_d = IDLE;
                     else if (last_wr) state_d = EVAL;
            EVAL:    state_d = bus.en ? COLLECT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q     <= '0;
            slot_idx  <= '0;
            chips_q   <= '0;
            thr_q     <= '0;
            sym_q     <= '0;
            peak_q    <= '0;
            erased_q  <= 1'b0;
            sym_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
            en_q      <= 1'b0;
            sym_cnt_q <= '0;
            era_cnt_q <= '0;
        end else begin
            buf_q <= buf_nxt;
            en_q  <= bus.en;

            // A restarted frame overwrites every slot before slot 15, so stale slots need no clearing.
            if (go_idle)                         slot_idx <= 4'd0;
            else if (wr_en)                      slot_idx <= wr_idx + 4'd1;
            else if (active && bus.frame_sync)   slot_idx <= 4'd0;

            if (last_wr) begin
                chips_q <= buf_nxt;
                thr_q   <= bus.cfg_threshold;
            end

            if (capture) begin
                sym_q     <= bus.corr_symbol;
                peak_q    <= bus.corr_peak;
                erased_q  <= bus.corr_unmet;
                sym_vld_q <= 1'b1;
            end else if (sym_vld_q && bus.sym_ready) begin
                sym_vld_q <= 1'b0;
            end

            if (drop)                     ovf_q <= 1'b1;
            else if (bus.en && !en_q)     ovf_q <= 1'b0;

            if (bus.cnt_clr) begin
                sym_cnt_q <= '0;
                era_cnt_q <= '0;
            end else if (capture) begin
                if (sym_cnt_q != 16'hFFFF) sym_cnt_q <= sym_cnt_q + 16'd1;
                if (bus.corr_unmet && era_cnt_q != 16'hFFFF) era_cnt_q <= era_cnt_q + 16'd1;
            end
        end
    end

    assign bus.corr_chips     = chips_q;
    assign bus.corr_valid     = (state_q == EVAL);
    assign bus.corr_threshold = thr_q;
    assign bus.sym_out        = sym_q;
    assign bus.sym_peak       = peak_q;
    assign bus.sym_erased     = erased_q;
    assign bus.sym_valid      = sym_vld_q;
    assign bus.overflow       = ovf_q;
    assign bus.sym_count      = sym_cnt_q;
    assign bus.erase_count    = era_cnt_q;

endmodule

// File: tb/tb_ppm16_frame_ctrl.sv
// Scoreboard bench for ppm16_frame_ctrl with a behavioural 1-bit PPM correlator on the side.
module tb_ppm16_frame_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ppm16_frame_ctrl_if #(.CHIP_BITS(1)) bus ();

    ppm16_frame_ctrl #(.CHIP_BITS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [3:0] sym;
        logic       peak;
        logic       erased;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    // External correlator: lowest slot holding the peak wins, unmet when peak < threshold.
    always_comb begin
        bus.corr_symbol = 4'd0;
        bus.corr_peak   = 1'b0;
        for (int k = 15; k >= 0; k--) begin
            if (bus.corr_chips[k]) begin
                bus.corr_symbol = 4'(k);
                bus.corr_peak   = 1'b1;
            end
        end
        bus.corr_unmet = (bus.corr_peak < bus.corr_threshold);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t frame_exp(input logic [15:0] pat);
        exp_t e;
        e.sym = 4'd0; e.peak = 1'b0; e.erased = 1'b1;
        for (int k = 15; k >= 0; k--) begin
            if (pat[k]) begin
                e.sym = 4'(k); e.peak = 1'b1; e.erased = 1'b0;
            end
        end
        return e;
    endfunction

    // Scoreboard pop on every accepted symbol.
    always @(negedge clk) begin
        if (!rst && bus.sym_valid && bus.sym_ready) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_sym",    32'(bus.sym_out),    32'(e.sym));
                chk("sb_peak",   32'(bus.sym_peak),   32'(e.peak));
                chk("sb_erased", 32'(bus.sym_erased), 32'(e.erased));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 16 chips back to back; corr_valid must stay low until the 16th and last exactly one cycle.
    task automatic send_frame(input logic [15:0] pat, input bit sync, input bit push, input bit clr);
        for (int i = 0; i < 16; i++) begin
            bus.chip_valid = 1'b1;
            bus.chip_in    = pat[i];
            bus.frame_sync = sync && (i == 0);
            tick();
            if (i < 15) chk("cv_early", 32'(bus.corr_valid), 32'd0);
        end
        bus.chip_valid = 1'b0;
        bus.frame_sync = 1'b0;
        chk("cv_pulse", 32'(bus.corr_valid), 32'd1);
        if (push) sb.push_back(frame_exp(pat));
        if (clr) bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        chk("cv_end", 32'(bus.corr_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.frame_sync = 1'b0; bus.chip_in = 1'b0; bus.chip_valid = 1'b0;
        bus.cfg_threshold = 1'b0; bus.cnt_clr = 1'b0; bus.sym_ready = 1'b1;
        repeat (3) tick();
        chk("rst_cv",    32'(bus.corr_valid),  32'd0);
        chk("rst_sv",    32'(bus.sym_valid),   32'd0);
        chk("rst_chips", 32'(bus.corr_chips),  32'd0);
        chk("rst_ovf",   32'(bus.overflow),    32'd0);
        chk("rst_cnt",   32'(bus.sym_count),   32'd0);

        rst = 1'b0; bus.en = 1'b1; bus.cfg_threshold = 1'b1;
        tick();

        // single pulse in slot 5
        send_frame(16'h0020, 1'b1, 1'b1, 1'b0);
        chk("s1_sv",    32'(bus.sym_valid),      32'd1);
        chk("s1_out",   32'(bus.sym_out),        32'd5);
        chk("s1_cnt",   32'(bus.sym_count),      32'd1);
        chk("s1_thr",   32'(bus.corr_threshold), 32'd1);
        chk("s1_chips", 32'(bus.corr_chips),     32'h0020);
        repeat (2) tick();
        chk("s1_acc",   32'(bus.sym_valid),      32'd0);

        // empty frame erases
        send_frame(16'h0000, 1'b1, 1'b1, 1'b0);
        chk("s2_era",  32'(bus.sym_erased),  32'd1);
        chk("s2_ecnt", 32'(bus.erase_count), 32'd1);
        chk("s2_cnt",  32'(bus.sym_count),   32'd2);
        repeat (2) tick();

        // back-pressure: second symbol dropped
        bus.sym_ready = 1'b0;
        send_frame(16'h0200, 1'b1, 1'b1, 1'b0);
        chk("s3_sv",  32'(bus.sym_valid), 32'd1);
        send_frame(16'h1000, 1'b1, 1'b0, 1'b0);
        chk("s3_ovf", 32'(bus.overflow),  32'd1);
        chk("s3_cnt", 32'(bus.sym_count), 32'd3);
        chk("s3_out", 32'(bus.sym_out),   32'd9);
        bus.sym_ready = 1'b1;
        tick();
        chk("s3_gone",  32'(bus.sym_valid), 32'd0);
        chk("s3_ovf_h", 32'(bus.overflow),  32'd1);
        bus.en = 1'b0;
        tick();
        bus.en = 1'b1;
        tick();
        chk("s3_ovf_clr", 32'(bus.overflow), 32'd0);

        // partial frame abandoned by frame_sync
        for (int i = 0; i < 7; i++) begin
            bus.chip_valid = 1'b1; bus.chip_in = 1'b1; bus.frame_sync = (i == 0);
            tick();
            chk("s4_partial_cv", 32'(bus.corr_valid), 32'd0);
        end
        send_frame(16'h0004, 1'b1, 1'b1, 1'b0);
        chk("s4_out", 32'(bus.sym_out),   32'd2);
        chk("s4_cnt", 32'(bus.sym_count), 32'd4);
        repeat (2) tick();

        // counter clear wins over the same-edge increment
        send_frame(16'h0080, 1'b1, 1'b1, 1'b1);
        chk("clr_cnt",  32'(bus.sym_count),   32'd0);
        chk("clr_ecnt", 32'(bus.erase_count), 32'd0);
        chk("clr_sv",   32'(bus.sym_valid),   32'd1);
        repeat (2) tick();

        // 32 continuous chips: two frames, the EVAL chip lands in slot 0
        for (int i = 0; i < 32; i++) begin
            bus.chip_valid = 1'b1;
            bus.chip_in    = (i == 3) || (i == 16);
            bus.frame_sync = (i == 0);
            tick();
            chk("s5_cv", 32'(bus.corr_valid), 32'((i == 15) || (i == 31)));
            if (i == 15) sb.push_back(frame_exp(16'h0008));
            if (i == 31) sb.push_back(frame_exp(16'h0001));
        end
        bus.chip_valid = 1'b0; bus.frame_sync = 1'b0;
        repeat (3) tick();
        chk("s5_cnt", 32'(bus.sym_count), 32'd2);

        // reset mid-frame
        for (int i = 0; i < 10; i++) begin
            bus.chip_valid = 1'b1; bus.chip_in = 1'b1; bus.frame_sync = (i == 0);
            tick();
        end
        bus.chip_valid = 1'b0; bus.frame_sync = 1'b0;
        rst = 1'b1;
        #1;
        chk("s6_cv",    32'(bus.corr_valid),     32'd0);
        chk("s6_sv",    32'(bus.sym_valid),      32'd0);
        chk("s6_cnt",   32'(bus.sym_count),      32'd0);
        chk("s6_chips", 32'(bus.corr_chips),     32'd0);
        chk("s6_thr",   32'(bus.corr_threshold), 32'd0);
        chk("s6_out",   32'(bus.sym_out),        32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        send_frame(16'h4000, 1'b1, 1'b1, 1'b0);
        chk("s6_out2", 32'(bus.sym_out),   32'd14);
        chk("s6_cnt2", 32'(bus.sym_count), 32'd1);
        repeat (3) tick();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
